// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment and HI/LO/CP0 architectural state; drives the register-file write port.
// Latency: one falling edge from ME to WB; HI/LO/CP0 writes land on the falling edge that ends WB.
// Backpressure: none, so the stage advances every cycle and squashed instructions arrive with zeroed enables.
module mem_wb_stage #(
    parameter int CP0_STATUS_IDX = 12,
    parameter int CP0_CAUSE_IDX  = 13,
    parameter int CP0_EPC_IDX    = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWr_me,
    input  logic [4:0]  Rw_me,
    input  logic [5:0]  op_me,
    input  logic [5:0]  func_me,
    input  logic [4:0]  Rs_me,
    input  logic [4:0]  Rd_me,
    input  logic [31:0] Result_me,
    input  logic [31:0] Result_next_me,
    input  logic [31:0] Dout_me,
    input  logic        Hi_wr_me,
    input  logic        Lo_wr_me,
    input  logic        Hi_Lo_wr_me,
    input  logic        CPR_wr_me,
    output logic        RegWr_wb,
    output logic [4:0]  Rw_wb,
    output logic [31:0] busW_wb,
    output logic [31:0] Hi_out,
    output logic [31:0] Lo_out,
    output logic [31:0] status_out,
    output logic [31:0] cause_out,
    output logic [31:0] epc_out
);

    localparam logic [4:0] STATUS_IDX = 5'(CP0_STATUS_IDX);
    localparam logic [4:0] CAUSE_IDX  = 5'(CP0_CAUSE_IDX);
    localparam logic [4:0] EPC_IDX    = 5'(CP0_EPC_IDX);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MFLO    = 6'b010010;

    logic        regwr_q;
    logic [4:0]  rw_q;
    logic [5:0]  op_q;
    logic [5:0]  func_q;
    logic [4:0]  rs_q;
    logic [4:0]  rd_q;
    logic [31:0] result_q;
    logic [31:0] result_next_q;
    logic [31:0] dout_q;
    logic        hi_wr_q;
    logic        lo_wr_q;
    logic        hi_lo_wr_q;
    logic        cpr_wr_q;
    logic [1:0]  addr_lo_q;

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;

    logic [7:0]  load_byte;
    logic [31:0] cp0_rd_dat;
    logic [31:0] busw;

    // Architectural writes use the WB-registered enables, so they commit as the writer leaves WB.
    always_ff @(negedge clk) begin
        if (rst) begin
            regwr_q       <= 1'b0;
            rw_q          <= 5'd0;
            op_q          <= 6'd0;
            func_q        <= 6'd0;
            rs_q          <= 5'd0;
            rd_q          <= 5'd0;
            result_q      <= 32'd0;
            result_next_q <= 32'd0;
            dout_q        <= 32'd0;
            hi_wr_q       <= 1'b0;
            lo_wr_q       <= 1'b0;
            hi_lo_wr_q    <= 1'b0;
            cpr_wr_q      <= 1'b0;
            addr_lo_q     <= 2'd0;
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            status_q      <= 32'd0;
            cause_q       <= 32'd0;
            epc_q         <= 32'd0;
        end else begin
            regwr_q       <= RegWr_me;
            rw_q          <= Rw_me;
            op_q          <= op_me;
            func_q        <= func_me;
            rs_q          <= Rs_me;
            rd_q          <= Rd_me;
            result_q      <= Result_me;
            result_next_q <= Result_next_me;
            dout_q        <= Dout_me;
            hi_wr_q       <= Hi_wr_me;
            lo_wr_q       <= Lo_wr_me;
            hi_lo_wr_q    <= Hi_Lo_wr_me;
            cpr_wr_q      <= CPR_wr_me;
            addr_lo_q     <= Result_me[1:0];

            if (hi_lo_wr_q) begin
                hi_q <= result_next_q;
                lo_q <= result_q;
            end else begin
                if (hi_wr_q) hi_q <= result_q;
                if (lo_wr_q) lo_q <= result_q;
            end

            if (cpr_wr_q) begin
                case (rd_q)
                    STATUS_IDX: status_q <= result_q;
                    CAUSE_IDX:  cause_q  <= result_q;
                    EPC_IDX:    epc_q    <= result_q;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        load_byte = 8'd0;
        case (addr_lo_q)
            2'd0: load_byte = dout_q[7:0];
            2'd1: load_byte = dout_q[15:8];
            2'd2: load_byte = dout_q[23:16];
            2'd3: load_byte = dout_q[31:24];
            default: load_byte = 8'd0;
        endcase
    end

    always_comb begin
        cp0_rd_dat = 32'd0;
        case (rd_q)
            STATUS_IDX: cp0_rd_dat = status_q;
            CAUSE_IDX:  cp0_rd_dat = cause_q;
            EPC_IDX:    cp0_rd_dat = epc_q;
            default:    cp0_rd_dat = 32'd0;
        endcase
    end

    always_comb begin
        busw = result_q;
        if (op_q == OP_LW)
            busw = dout_q;
        else if (op_q == OP_LB)
            busw = {{24{load_byte[7]}}, load_byte};
        else if (op_q == OP_LBU)
            busw = {24'd0, load_byte};
        else if (op_q == OP_SPECIAL && func_q == FN_MFHI)
            busw = hi_q;
        else if (op_q == OP_SPECIAL && func_q == FN_MFLO)
            busw = lo_q;
        else if (op_q == OP_COP0 && rs_q == 5'd0)
            busw = cp0_rd_dat;
    end

    assign RegWr_wb   = regwr_q & (rw_q != 5'd0);
    assign Rw_wb      = rw_q;
    assign busW_wb    = busw;
    assign Hi_out     = hi_q;
    assign Lo_out     = lo_q;
    assign status_out = status_q;
    assign cause_out  = cause_q;
    assign epc_out    = epc_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register plus writeback-side architectural state for the 5-stage MIPS core. It sits directly downstream of the EX/MEM register. It consumes the ME-stage control, result and data-memory read data, and performs load byte alignment. It owns the HI, LO and CP0 (Status/Cause/EPC) registers and drives the register-file write port (RegWr_wb, Rw_wb, busW_wb).

Parameters:
CP0_STATUS_IDX, 12, CP0 index of Status
CP0_CAUSE_IDX, 13, CP0 index of Cause
CP0_EPC_IDX, 14, CP0 index of EPC

Ports:
clk  input  1  core clock; all state updates on falling edge, same as the other pipeline registers
rst  input  1  synchronous, active-high reset
RegWr_me  input  1  ME-stage register write enable (already squashed for loaduse/xiaoc)
Rw_me  input  5  ME-stage destination register
op_me  input  6  ME-stage opcode
func_me  input  6  ME-stage function field
Rs_me  input  5  ME-stage rs field (distinguishes mfc0/mtc0)
Rd_me  input  5  ME-stage rd field (CP0 index)
Result_me  input  32  ALU result / memory address / mtc0, mthi, mtlo data / mult low word
Result_next_me  input  32  mult high word
Dout_me  input  32  word read from data memory at Result_me[31:2]
Hi_wr_me, Lo_wr_me, Hi_Lo_wr_me, CPR_wr_me  input  1 each  squashed write enables from ME stage
RegWr_wb  output  1  register-file write enable
Rw_wb  output  5  register-file write address
busW_wb  output  32  register-file write data (also the WB forwarding value)
Hi_out, Lo_out  output  32 each  current HI/LO contents
status_out, cause_out, epc_out  output  32 each  current CP0 contents

Behaviour:
- Pipeline register, captured every falling edge: RegWr, Rw, op, func, Rs, Rd, Result, Result_next, Dout, Hi_wr, Lo_wr, Hi_Lo_wr, CPR_wr, addr_lo (Result_me[1:0]). There is no stall or flush input; squash arrives via the zeroed enables.
- rst high at a falling edge clears all WB registers, HI, LO, Status, Cause and EPC to 0. rst has priority over every write.
- Reset values: RegWr_wb = 0, Rw_wb = 0, busW_wb = 0, and all state outputs = 0.
- RegWr_wb = RegWr_wb_reg & (Rw_wb != 0). A write to $0 is never issued.
- busW_wb is combinational from WB registers. Priority order:
  1. lw (100011) -> Dout_wb.
  2. lb (100000) -> sign-extended byte; lbu (100100) -> zero-extended byte. Byte is Dout_wb[8*addr_lo+7 : 8*addr_lo], little-endian.
  3. mfhi (op 000000, func 010000) -> HI.
  4. mflo (op 000000, func 010010) -> LO.
  5. mfc0 (op 010000, Rs 00000) -> CP0[Rd_wb]. An unimplemented index reads 0.
  6. Otherwise -> Result_wb.
- HI/LO writes occur at the falling edge that ends WB, from the WB-registered enables:
  - Hi_wr -> HI <= Result_wb.
  - Lo_wr -> LO <= Result_wb.
  - Hi_Lo_wr -> HI <= Result_next_wb and LO <= Result_wb. This has priority over Hi_wr/Lo_wr if several are set.
- CP0 write: CPR_wr -> CP0[Rd_wb] <= Result_wb when Rd_wb is 12, 13 or 14. Other indices are ignored.
- Read-after-write: an mfhi/mflo/mfc0 in WB one cycle after the writer sees the new value, because the write lands at the edge that ends the writer's WB. No internal bypass. The 1-cycle latency ME->WB is fixed.
- A mfhi in WB in the same cycle as a write is impossible; only one instruction is in WB at a time.
- rst asserted mid-stream: the in-flight WB instruction is discarded and its HI/LO/CP0 write is suppressed on that edge.

Test Plan:
1. Reset for 2 edges, then release -> RegWr_wb=0, busW_wb=0, Hi_out=Lo_out=epc_out=0.
2. lb with Dout_me=32'h80FF7F01, Result_me[1:0]=2 -> busW_wb=32'hFFFFFFFF; lbu with the same inputs -> 32'h000000FF; addr 0 lb -> 32'h00000001; lw -> 32'h80FF7F01.
3. mult writeback with Result_next_me=32'h1, Result_me=32'h2, Hi_Lo_wr_me=1, followed next cycle by mfhi then mflo -> busW_wb=1 then 2, Rw_wb=instruction rd.
4. mtc0 Rd=14 with Result_me=32'h00400020, then mfc0 Rd=14 -> epc_out=32'h00400020 and busW_wb=32'h00400020. mtc0 Rd=9 -> no CP0 change, and mfc0 Rd=9 returns 0.
5. R-type with Rw_me=0, RegWr_me=1, Result_me=32'hDEAD -> RegWr_wb=0. The same with Rw_me=5 -> RegWr_wb=1, busW_wb=32'hDEAD.
6. rst asserted on the edge that would complete mthi(32'h55) -> Hi_out remains 0, and RegWr_wb=0 afterwards.
